// File: rtl/lcd_msg_writer.sv
// Avalon-MM master that refreshes a COLS x ROWS character LCD from a loadable message buffer.
// Optional scroll input and message offset are enabled by defining LCD_MSG_SCROLL_EN.
module lcd_msg_writer #(
  parameter int COLS    = 16,
  parameter int ROWS    = 2,
  parameter int MSG_LEN = 32,
  parameter int AW      = $clog2(MSG_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          msg_we,
  input  logic [AW-1:0] msg_addr,
  input  logic [7:0]    msg_data,
  input  logic          start,
`ifdef LCD_MSG_SCROLL_EN
  input  logic          scroll,
`endif
  output logic          busy,
  output logic          done,
  output logic          address,
  output logic          chipselect,
  output logic          write,
  output logic [7:0]    writedata,
  input  logic          waitrequest
);

  typedef enum logic [1:0] {IDLE, ROW_CMD, CHAR, DONE} state_t;

  localparam logic [AW:0] LEN_W    = (AW+1)'(MSG_LEN);
  localparam logic [AW:0] ONE_W    = (AW+1)'(1);
  localparam logic [5:0]  LAST_COL = 6'(COLS-1);
  localparam logic [1:0]  LAST_ROW = 2'(ROWS-1);

  state_t        state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [5:0]    col_q, col_d;
  logic [AW:0]   pos_q, pos_d;
  logic [AW-1:0] offset_q;
  logic          busy_q, busy_d, done_q, done_d;
  logic          addr_q, addr_d, cs_q, cs_d, wr_q, wr_d;
  logic [7:0]    wd_q, wd_d;
  logic [7:0]    mem_q [MSG_LEN];
  logic [AW:0]   sum_s;
  logic [AW-1:0] idx_s;
  logic [7:0]    char_s;
  logic          go_s, accept_s;

  function automatic logic [7:0] row_cmd(input logic [1:0] r);
    case (r)
      2'd0:    row_cmd = 8'h80;
      2'd1:    row_cmd = 8'hC0;
      2'd2:    row_cmd = 8'h94;
      2'd3:    row_cmd = 8'hD4;
      default: row_cmd = 8'h80;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) mem_q[i] <= 8'h20;
    end else if (msg_we && ({1'b0, msg_addr} < LEN_W)) begin
      mem_q[msg_addr] <= msg_data;
    end
  end

`ifdef LCD_MSG_SCROLL_EN
  logic [AW-1:0] offset_d;

  // A scroll seen in IDLE advances the window and doubles as a start request.
  always_comb begin
    offset_d = offset_q;
    if (state_q == IDLE && scroll) begin
      offset_d = (offset_q == AW'(MSG_LEN-1)) ? '0 : offset_q + AW'(1);
    end else begin
      offset_d = offset_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) offset_q <= '0;
    else       offset_q <= offset_d;
  end

  assign go_s = (state_q == IDLE) && (start || scroll);
`else
  assign offset_q = '0;
  assign go_s     = (state_q == IDLE) && start;
`endif

  // Character index modulo MSG_LEN by compare-and-subtract; pos_q is always < MSG_LEN when used.
  always_comb begin
    sum_s = {1'b0, offset_q} + pos_q;
    if (sum_s >= LEN_W) idx_s = AW'(sum_s - LEN_W);
    else                idx_s = sum_s[AW-1:0];
    char_s = mem_q[idx_s];
  end

  assign accept_s = wr_q && !waitrequest;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    pos_d   = pos_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    cs_d    = cs_q;
    wr_d    = wr_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if (go_s) begin
          state_d = ROW_CMD;
          row_d   = 2'd0;
          col_d   = 6'd0;
          pos_d   = '0;
          busy_d  = 1'b1;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = 1'b0;
          wd_d    = row_cmd(2'd0);
        end else begin
          state_d = IDLE;
        end
      end
      ROW_CMD: begin
        if (accept_s) begin
          state_d = CHAR;
          col_d   = 6'd0;
          addr_d  = 1'b1;
          wd_d    = char_s;
          pos_d   = pos_q + ONE_W;
        end else begin
          state_d = ROW_CMD;
        end
      end
      CHAR: begin
        if (!accept_s) begin
          state_d = CHAR;
        end else if (col_q < LAST_COL) begin
          col_d  = col_q + 6'd1;
          addr_d = 1'b1;
          wd_d   = char_s;
          pos_d  = pos_q + ONE_W;
        end else if (row_q < LAST_ROW) begin
          state_d = ROW_CMD;
          row_d   = row_q + 2'd1;
          addr_d  = 1'b0;
          wd_d    = row_cmd(row_q + 2'd1);
        end else begin
          state_d = DONE;
          cs_d    = 1'b0;
          wr_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= 2'd0;
      col_q   <= 6'd0;
      pos_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= 1'b0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      wd_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pos_q   <= pos_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign address    = addr_q;
  assign chipselect = cs_q;
  assign write      = wr_q;
  assign writedata  = wd_q;

endmodule

// File: tb/tb_lcd_msg_writer.sv
// Directed bench for lcd_msg_writer (default 16x2, 32-byte buffer); scroll tests under LCD_MSG_SCROLL_EN.
module tb_lcd_msg_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       msg_we = 1'b0;
  logic [4:0] msg_addr = 5'd0;
  logic [7:0] msg_data = 8'h00;
  logic       start = 1'b0;
  logic       scroll = 1'b0;
  logic       busy, done, address, chipselect, write;
  logic [7:0] writedata;
  logic       waitrequest = 1'b0;

  always #5 clk = ~clk;

  lcd_msg_writer dut (
    .clk(clk), .reset(reset), .msg_we(msg_we), .msg_addr(msg_addr), .msg_data(msg_data),
    .start(start),
`ifdef LCD_MSG_SCROLL_EN
    .scroll(scroll),
`endif
    .busy(busy), .done(done), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .waitrequest(waitrequest)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Slave model: stalls each transfer 3 cycles when enabled, logs accepted transfers.
  logic       stall_en = 1'b0;
  int         stall_cnt = 0;
  logic [8:0] log_q [4096];
  int         log_n = 0;
  int         done_n = 0;
  int         busy_n = 0;
  logic       held_v = 1'b0;
  logic [8:0] held = 9'h000;

  initial begin
    forever begin
      @(negedge clk);
      if (held_v && !reset) chk("stall_hold", 32'({address, writedata}), 32'(held));
      if (stall_en && write && stall_cnt < 3) begin
        waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        waitrequest = 1'b0;
        stall_cnt = 0;
      end
      held_v = write && waitrequest;
      held = {address, writedata};
      if (write && !waitrequest && !reset && log_n < 4096) begin
        log_q[log_n] = {address, writedata};
        log_n++;
      end
      if (done) done_n++;
      if (busy) busy_n++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    int         idx;
    logic [8:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr_buf(input logic [4:0] a, input logic [7:0] d);
    msg_we = 1'b1;
    msg_addr = a;
    msg_data = d;
    tick();
    msg_we = 1'b0;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 1;
    while (!done && n < 2000) begin
      tick();
      n++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  vec_t vecs[$];
  int   base, base2, d0, b0, n, bad;

  initial begin
    repeat (3) tick();
    chk("reset_outputs", 32'({busy, done, address, chipselect, write, writedata}), 32'd0);
    reset = 1'b0;
    tick();

    // Blank refresh, no stalls.
    base = log_n; d0 = done_n; b0 = busy_n;
    pulse_start();
    wait_done("t1_done_seen", n);
    chk("t1_latency", 32'(n), 32'd35);
    repeat (3) tick();
    chk("t1_xfers", 32'(log_n - base), 32'd34);
    chk("t1_busy_cycles", 32'(busy_n - b0), 32'd34);
    chk("t1_done_pulses", 32'(done_n - d0), 32'd1);
    vecs = {};
    vecs.push_back('{"t1_cmd_row0", 0, 9'h080});
    vecs.push_back('{"t1_first_char", 1, 9'h120});
    vecs.push_back('{"t1_last_row0", 16, 9'h120});
    vecs.push_back('{"t1_cmd_row1", 17, 9'h0C0});
    vecs.push_back('{"t1_last_char", 33, 9'h120});
    foreach (vecs[k]) chk(vecs[k].name, 32'(log_q[base + vecs[k].idx]), 32'(vecs[k].exp));
    bad = 0;
    for (int i = 0; i < 34; i++) begin
      if (log_q[base + i] !== ((i == 0) ? 9'h080 : (i == 17) ? 9'h0C0 : 9'h120)) bad++;
    end
    chk("t1_pattern_bad", 32'(bad), 32'd0);

    // HELLO with 3-cycle stall on every transfer.
    wr_buf(5'd0, 8'h48); wr_buf(5'd1, 8'h45); wr_buf(5'd2, 8'h4C);
    wr_buf(5'd3, 8'h4C); wr_buf(5'd4, 8'h4F);
    stall_en = 1'b1;
    base = log_n;
    pulse_start();
    wait_done("t2_done_seen", n);
    chk("t2_latency", 32'(n), 32'd137);
    stall_en = 1'b0;
    repeat (3) tick();
    chk("t2_xfers", 32'(log_n - base), 32'd34);
    vecs = {};
    vecs.push_back('{"t2_cmd", 0, 9'h080});
    vecs.push_back('{"t2_H", 1, 9'h148});
    vecs.push_back('{"t2_E", 2, 9'h145});
    vecs.push_back('{"t2_L1", 3, 9'h14C});
    vecs.push_back('{"t2_L2", 4, 9'h14C});
    vecs.push_back('{"t2_O", 5, 9'h14F});
    vecs.push_back('{"t2_space", 6, 9'h120});
    vecs.push_back('{"t2_cmd_row1", 17, 9'h0C0});
    foreach (vecs[k]) chk(vecs[k].name, 32'(log_q[base + vecs[k].idx]), 32'(vecs[k].exp));

    // Start while busy is ignored.
    base = log_n; d0 = done_n;
    pulse_start();
    repeat (8) tick();
    pulse_start();
    wait_done("t3_done_seen", n);
    repeat (40) tick();
    chk("t3_done_pulses", 32'(done_n - d0), 32'd1);
    chk("t3_xfers", 32'(log_n - base), 32'd34);
    chk("t3_idle_busy", 32'(busy), 32'd0);

    // Buffer writes during a refresh: future byte shows now, past byte shows next time.
    base = log_n;
    pulse_start();
    repeat (3) tick();
    wr_buf(5'd20, 8'h41);
    wr_buf(5'd0, 8'h5A);
    wait_done("t5_done_seen", n);
    repeat (3) tick();
    chk("t5_row1_col4", 32'(log_q[base + 22]), 32'h141);
    chk("t5_old_first", 32'(log_q[base + 1]), 32'h148);
    base2 = log_n;
    pulse_start();
    wait_done("t5b_done_seen", n);
    repeat (3) tick();
    chk("t5_new_first", 32'(log_q[base2 + 1]), 32'h15A);

    // Reset mid-CHAR while stalled.
    stall_en = 1'b1;
    d0 = done_n;
    pulse_start();
    repeat (20) tick();
    n = 0;
    while (!(write && address && waitrequest) && n < 20) begin
      tick();
      n++;
    end
    chk("t4_found_stall", 32'({write, address, waitrequest}), 32'h7);
    reset = 1'b1;
    tick();
    chk("t4_bus_dropped", 32'({write, chipselect, busy, done}), 32'd0);
    tick();
    reset = 1'b0;
    stall_en = 1'b0;
    repeat (40) tick();
    chk("t4_no_done", 32'(done_n - d0), 32'd0);
    base = log_n;
    pulse_start();
    wait_done("t4_done_seen", n);
    repeat (3) tick();
    chk("t4_cmd", 32'(log_q[base]), 32'h080);
    bad = 0;
    for (int i = 1; i < 34; i++) begin
      if (i != 17 && log_q[base + i] !== 9'h120) bad++;
    end
    chk("t4_buffer_blank", 32'(bad), 32'd0);

`ifdef LCD_MSG_SCROLL_EN
    for (int i = 0; i < 32; i++) wr_buf(5'(i), 8'(8'h30 + i));
    base = log_n;
    scroll = 1'b1;
    tick();
    scroll = 1'b0;
    wait_done("s1_done_seen", n);
    repeat (3) tick();
    chk("s1_first", 32'(log_q[base + 1]), 32'h131);
    chk("s1_last_wrap", 32'(log_q[base + 33]), 32'h130);
    for (int k = 0; k < 31; k++) begin
      base = log_n;
      scroll = 1'b1;
      start = 1'b1;
      tick();
      scroll = 1'b0;
      start = 1'b0;
      wait_done("s2_done_seen", n);
      repeat (2) tick();
    end
    chk("s2_first_after_32", 32'(log_q[base + 1]), 32'h130);
    chk("s2_single_refresh", 32'(log_n - base), 32'd34);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
